alu_pipe: RTL



---
 rtl/alu_pkg.sv | 21 ++
 rtl/alu_core.sv | 63 ++++++
 rtl/alu_pipe.sv | 92 +++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the pipelined ALU: operation codes and flag bit positions.
package alu_pkg;

    typedef enum logic [2:0] {
        ADD = 3'd0,
        SUB = 3'd1,
        SLL = 3'd2,
        LSR = 3'd3,
        AND = 3'd4,
        OR  = 3'd5,
        XOR = 3'd6,
        EQL = 3'd7
    } alu_op_e;

    localparam int NUM_FLG = 4;
    localparam int FLG_Z   = 0;
    localparam int FLG_N   = 1;
    localparam int FLG_V   = 2;
    localparam int FLG_C   = 3;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath: result plus {C, V, N, Z} flags for one operation.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH) + 1
) (
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  alu_op_e            op,
    output logic [WIDTH-1:0]   res,
    output logic [NUM_FLG-1:0] flags
);

    localparam int MSB = WIDTH - 1;

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [SHW-1:0]   sh_amt;
    logic             sh_oor;
    logic             c;
    logic             v;

    // Any amount >= WIDTH saturates to zero instead of wrapping on the low bits.
    assign sh_amt = b[SHW-1:0];
    assign sh_oor = (|(b >> SHW)) || (sh_amt >= SHW'(WIDTH));
    assign sum    = {1'b0, a} + {1'b0, b};
    assign diff   = {1'b0, a} - {1'b0, b};

    always_comb begin
        res = '0;
        c   = 1'b0;
        v   = 1'b0;
        case (op)
            ADD: begin
                res = sum[WIDTH-1:0];
                c   = sum[WIDTH];
                v   = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
            end
            SUB: begin
                res = diff[WIDTH-1:0];
                c   = diff[WIDTH];
                v   = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]);
            end
            SLL:     res = sh_oor ? '0 : (a << sh_amt);
            LSR:     res = sh_oor ? '0 : (a >> sh_amt);
            AND:     res = a & b;
            OR:      res = a | b;
            XOR:     res = a ^ b;
            EQL:     res = {{(WIDTH-1){1'b0}}, (a == b)};
            default: res = '0;
        endcase
    end

    always_comb begin
        flags        = '0;
        flags[FLG_C] = c;
        flags[FLG_V] = v;
        flags[FLG_N] = res[MSB];
        flags[FLG_Z] = (res == '0);
    end

endmodule

// File: rtl/alu_pipe.sv
// Two-stage ALU pipeline with valid/ready on both sides; stage 1 holds operands,
// stage 2 holds the registered result and flags.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [2:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_res,
    output logic [3:0]       out_flags
);

    localparam int SHW    = $clog2(WIDTH) + 1;
    localparam int STAGES = 2;

    logic [STAGES:1]    vld_pipe_q, vld_pipe_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
    alu_op_e            op_q, op_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic [NUM_FLG-1:0] flags_q, flags_d;
    logic [WIDTH-1:0]   core_res;
    logic [NUM_FLG-1:0] core_flags;
    logic               s2_adv;
    logic               accept;

    alu_core #(.WIDTH(WIDTH), .SHW(SHW)) u_core (
        .a     (a_q),
        .b     (b_q),
        .op    (op_q),
        .res   (core_res),
        .flags (core_flags)
    );

    assign s2_adv   = !vld_pipe_q[2] || out_ready;
    assign in_ready = !vld_pipe_q[1] || s2_adv;
    assign accept   = in_valid && in_ready;

    always_comb begin
        vld_pipe_d = vld_pipe_q;
        a_d        = a_q;
        b_d        = b_q;
        op_d       = op_q;
        res_d      = res_q;
        flags_d    = flags_q;
        // Stage 1 may drain and reload in the same cycle, keeping full throughput.
        vld_pipe_d[1] = accept || (vld_pipe_q[1] && !s2_adv);
        if (accept) begin
            a_d  = in_a;
            b_d  = in_b;
            op_d = alu_op_e'(in_op);
        end
        if (s2_adv) begin
            vld_pipe_d[2] = vld_pipe_q[1];
            if (vld_pipe_q[1]) begin
                res_d   = core_res;
                flags_d = core_flags;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_pipe_q <= '0;
            res_q      <= '0;
            flags_q    <= '0;
        end else begin
            vld_pipe_q <= vld_pipe_d;
            res_q      <= res_d;
            flags_q    <= flags_d;
        end
    end

    // Operand registers need no reset: they are only consumed under vld_pipe_q[1].
    always_ff @(posedge clk) begin
        a_q  <= a_d;
        b_q  <= b_d;
        op_q <= op_d;
    end

    assign out_valid = vld_pipe_q[2];
    assign out_res   = res_q;
    assign out_flags = flags_q;

endmodule
